load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter none; all widths are fixed at 32-bit data and 32-bit byte address.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port req_i, input, 1, core access request, sampled only in IDLE.
REQ-005 SHALL have port we_i, input, 1, 1=store, 0=load.
REQ-006 SHALL have port size_i, input, 2, 00=byte, 01=half, 10/11=word.
REQ-007 SHALL have port unsigned_i, input, 1, 1=zero-extend loads, 0=sign-extend loads.
REQ-008 SHALL have port addr_i, input, 32, byte address.
REQ-009 SHALL have port wdata_i, input, 32, store data, right-aligned.
REQ-010 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rdata_o, output, 32, extended load result, valid while done_o=1.
REQ-013 SHALL have port err_o, output, 1, misaligned-access flag, valid while done_o=1.
REQ-014 SHALL have ports mem_rd_en_o (out 1), mem_wr_en_o (out 1), mem_addr_o (out 32), mem_wdata_o (out 32), mem_rdata_i (in 32), mem_ack_i (in 1), the word-memory port.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 SHALL capture addr_i, size_i, we_i, unsigned_i, wdata_i in IDLE when req_i=1 and ignore req_i in all other states.
REQ-017 SHALL drive mem_addr_o = {captured addr[31:2], 2'b00} in READ and WRITE, and 0 otherwise.
REQ-018 SHALL never assert mem_rd_en_o and mem_wr_en_o in the same cycle.
REQ-019 SHALL transition IDLE->READ for loads and sub-word stores, and IDLE->WRITE for word stores.
REQ-020 SHALL assert mem_rd_en_o in READ, hold there until mem_ack_i=1, then latch mem_rdata_i and go to DONE (load) or WRITE (sub-word store).
REQ-021 SHALL, in WRITE, drive mem_wdata_o = latched word with only the addressed byte (addr[1:0]) or half (addr[1]) lanes replaced by wdata_i[7:0]/[15:0], or wdata_i for word stores; hold mem_wr_en_o until mem_ack_i=1, then go to DONE.
REQ-022 SHALL, in DONE, pulse done_o for one cycle, present rdata_o (loads: selected lane, sign/zero-extended; stores: 0), and return to IDLE.
REQ-023 SHALL, with mem_ack_i tied high and req at cycle t, assert done_o at t+2 for loads and word stores and at t+3 for sub-word stores.
REQ-024 SHALL accept a new request in the IDLE cycle immediately following DONE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and drive busy_o, done_o, err_o, rdata_o, and all mem_* outputs to 0 from the following cycle.
REQ-026 SHALL abandon any in-flight access on reset and SHALL NOT issue a write strobe after the reset edge.

Configuration
REQ-027 SHALL, with MISALIGN_TRAP_EN defined, treat half with addr[0]=1 or word with addr[1:0]!=0 as misaligned: IDLE->DONE directly with no mem_* strobes, done_o=1 and err_o=1 at t+1, rdata_o=0.
REQ-028 SHALL, without MISALIGN_TRAP_EN, ignore low address bits that are irrelevant for the size (half uses addr[1] only; word ignores addr[1:0]), tie err_o to 0, and never take the misalignment path.

Verification
REQ-029 SHALL cover: memory word@0x10=0x8899AABB; load byte, signed, addr 0x13 -> done_o at t+2, rdata_o=0xFFFFFF88; same access unsigned -> 0x00000088.
REQ-030 SHALL cover: word@0x20=0x11223344; store half 0xBEEF to 0x22 -> one READ, then WRITE with mem_wdata_o=0xBEEF3344, done_o at t+3.
REQ-031 SHALL cover: store word 0xDEADBEEF to 0x30 -> no mem_rd_en_o cycle, mem_wr_en_o one cycle, done_o at t+2, a subsequent word load returns 0xDEADBEEF.
REQ-032 SHALL cover: mem_ack_i held low for 3 cycles in READ -> FSM stays in READ and done_o is delayed by exactly 3 cycles.
REQ-033 SHALL cover: load word from 0x41 -> with MISALIGN_TRAP_EN, err_o=1 and done_o=1 at t+1 with no strobes; without it, the word@0x40 is returned and err_o=0.
REQ-034 SHALL cover: rst asserted in the READ cycle of a sub-word store -> memory contents unchanged, all outputs 0 the next cycle, and a new request is accepted after rst deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a 32-bit word memory; sub-word stores are read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete immediately with err_o set.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic        we_reg;
    logic        unsigned_reg;
    logic [31:0] wdata_reg;
    logic [31:0] word_reg;
    logic        err_reg;

    logic        capture;
    logic        misalign;
    logic [31:0] merged_word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;

    assign capture = (state_reg == IDLE) && req_i;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            size_reg     <= '0;
            we_reg       <= 1'b0;
            unsigned_reg <= 1'b0;
            wdata_reg    <= '0;
            word_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                addr_reg     <= addr_i;
                size_reg     <= size_i;
                we_reg       <= we_i;
                unsigned_reg <= unsigned_i;
                wdata_reg    <= wdata_i;
                err_reg      <= misalign;
            end
            if ((state_reg == READ) && mem_ack_i)
                word_reg <= mem_rdata_i;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    if (misalign)
                        state_next = DONE;
                    else if (we_i && size_i[1])
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                mem_rd_en_o = 1'b1;
                if (mem_ack_i)
                    state_next = we_reg ? WRITE : DONE;
            end
            WRITE: begin
                mem_wr_en_o = 1'b1;
                if (mem_ack_i)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-lane merge of store data into the previously read word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_sel;
            logic [7:0] lane_src;
            always_comb begin
                if (size_reg[1]) begin
                    lane_sel = 1'b1;
                    lane_src = wdata_reg[gi*8 +: 8];
                end else if (size_reg[0]) begin
                    lane_sel = (addr_reg[1] == 1'(gi / 2));
                    lane_src = wdata_reg[(gi % 2)*8 +: 8];
                end else begin
                    lane_sel = (addr_reg[1:0] == 2'(gi));
                    lane_src = wdata_reg[7:0];
                end
            end
            assign merged_word[gi*8 +: 8] = lane_sel ? lane_src : word_reg[gi*8 +: 8];
        end
    endgenerate

    assign byte_val = word_reg[{addr_reg[1:0], 3'b000} +: 8];
    assign half_val = addr_reg[1] ? word_reg[31:16] : word_reg[15:0];

    always_comb begin
        if (size_reg[1])
            load_val = word_reg;
        else if (size_reg[0])
            load_val = {{16{~unsigned_reg & half_val[15]}}, half_val};
        else
            load_val = {{24{~unsigned_reg & byte_val[7]}}, byte_val};
    end

    assign busy_o      = (state_reg != IDLE);
    assign done_o      = (state_reg == DONE);
    assign err_o       = done_o && err_reg;
    assign rdata_o     = (done_o && !we_reg && !err_reg) ? load_val : 32'h0;
    assign mem_addr_o  = (mem_rd_en_o || mem_wr_en_o) ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign mem_wdata_o = mem_wr_en_o ? merged_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses against a word-memory model.
// Define MISALIGN_TRAP_EN for both bench and RTL to check the trapping build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_ack_i;

    logic [31:0] mem [0:63];

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o[7:2]];
    always @(posedge clk)
        if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[7:2]] <= mem_wdata_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          done_cyc;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int rd_cnt = 0, wr_cnt = 0, total_wr = 0;
    logic [31:0] last_wdata = '0, last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: counts strobes and checks each completion against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (mem_rd_en_o) begin rd_cnt++; last_addr = mem_addr_o; end
                if (mem_wr_en_o) begin
                    wr_cnt++; total_wr++;
                    last_addr = mem_addr_o; last_wdata = mem_wdata_o;
                end
                if (mem_rd_en_o && mem_wr_en_o) chk("rd_wr_exclusive", 32'd1, 32'd0);
                if (done_o) begin
                    done_count++;
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rdata", rdata_o, e.rdata);
                        chk("err", 32'(err_o), 32'(e.err));
                        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        chk("busy_in_done", 32'(busy_o), 32'd1);
                        chk("rd_strobes", 32'(rd_cnt), 32'(e.nrd));
                        chk("wr_strobes", 32'(wr_cnt), 32'(e.nwr));
                        if (e.nwr > 0) chk("mem_wdata", last_wdata, e.wdata);
                        if (e.nrd + e.nwr > 0) chk("mem_addr", last_addr, e.waddr);
                        $display("[TB] txn done cyc=%0d rdata=%h err=%0d rd=%0d wr=%0d",
                                 cyc, rdata_o, err_o, rd_cnt, wr_cnt);
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    // Issue one access in the current cycle and wait for its completion.
    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input int nrd, input int nwr, input logic [31:0] exp_wdata, input int stall);
        exp_t e;
        int start;
        start = done_count;
        e.rdata = exp_rdata; e.err = exp_err; e.done_cyc = cyc + lat;
        e.nrd = nrd; e.nwr = nwr; e.wdata = exp_wdata; e.waddr = {addr[31:2], 2'b00};
        q.push_back(e);
        if (stall > 0) mem_ack_i = 1'b0;
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
        @(posedge clk); #1;
        req_i = 1'b0; addr_i = '0; wdata_i = '0;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 mem_ack_i = 1'b1;
        end
        for (int i = 0; i < 30 && done_count == start; i++) @(posedge clk);
        if (done_count == start) begin
            chk("timeout", 32'd0, 32'd1);
            q.delete();
        end
        #1;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctl"}, 32'({busy_o, done_o, err_o, mem_rd_en_o, mem_wr_en_o}), 32'd0);
        chk({name, "_rdata"}, rdata_o, 32'h0);
        chk({name, "_maddr"}, mem_addr_o, 32'h0);
        chk({name, "_mwdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'h8899AABB;
        mem[32'h20 >> 2] = 32'h11223344;
        mem[32'h40 >> 2] = 32'hCAFEF00D;
        mem[32'h50 >> 2] = 32'h55667788;
        rst = 1'b1; req_i = 0; we_i = 0; size_i = 0; unsigned_i = 0;
        addr_i = 0; wdata_i = 0; mem_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // we, size, uns, addr, wdata, exp_rdata, exp_err, lat, nrd, nwr, exp_wdata, stall
        do_op(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF88, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b00, 1, 32'h13, 0, 32'h00000088, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b01, 0, 32'h10, 0, 32'hFFFFAABB, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b01, 1, 32'h12, 0, 32'h00008899, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b00, 0, 32'h21, 0, 32'h00000033, 0, 2, 1, 0, 0, 0);
        do_op(1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF3344, 0);
        do_op(0, 2'b10, 0, 32'h20, 0, 32'hBEEF3344, 0, 2, 1, 0, 0, 0);
        do_op(1, 2'b00, 0, 32'h21, 32'hFFFFFF5A, 32'h0, 0, 3, 1, 1, 32'hBEEF5A44, 0);
        do_op(0, 2'b11, 0, 32'h20, 0, 32'hBEEF5A44, 0, 2, 1, 0, 0, 0);
        do_op(1, 2'b10, 0, 32'h30, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF, 0);
        do_op(0, 2'b10, 0, 32'h30, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 5, 4, 0, 0, 3);
`ifdef MISALIGN_TRAP_EN
        do_op(0, 2'b10, 0, 32'h41, 0, 32'h0, 1, 1, 0, 0, 0, 0);
        do_op(0, 2'b01, 0, 32'h43, 0, 32'h0, 1, 1, 0, 0, 0, 0);
`else
        do_op(0, 2'b10, 0, 32'h41, 0, 32'hCAFEF00D, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b01, 0, 32'h43, 0, 32'hFFFFCAFE, 0, 2, 1, 0, 0, 0);
`endif

        // Reset during the READ of a sub-word store must abandon it without writing.
        wr_before = total_wr;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 0;
        addr_i = 32'h51; wdata_i = 32'h000000EE;
        @(posedge clk); #1;
        req_i = 1'b0;
        chk("rst_in_read_state", 32'(mem_rd_en_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("after_rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_no_write", 32'(total_wr - wr_before), 32'd0);
        chk("rst_mem_unchanged", mem[32'h50 >> 2], 32'h55667788);
        @(posedge clk); #1;
        do_op(0, 2'b10, 0, 32'h50, 0, 32'h55667788, 0, 2, 1, 0, 0, 0);
        do_op(0, 2'b00, 1, 32'h51, 0, 32'h00000077, 0, 2, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
